// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer with frame resync, a valid/ready
// holding register and sticky overrun detection.
module sipo_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CNT_W    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_in,
  input  logic             enable,
  input  logic             sof,
  input  logic             out_ready,
  input  logic             overrun_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             overrun,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic {EMPTY, FULL} hold_state_e;

  hold_state_e      state, state_next;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic             word_done;
  logic             load;
  logic             set_ovr;

  always_comb begin
    if (MSB_FIRST) shreg_next = {shreg[WIDTH-2:0], data_in};
    else           shreg_next = {data_in, shreg[WIDTH-1:1]};
  end

  // An sof bit restarts the count, so it never completes a word.
  assign word_done = enable && !sof && (bit_cnt == CNT_W'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (enable) begin
      shreg <= shreg_next;
      if (sof)            bit_cnt <= CNT_W'(1);
      else if (word_done) bit_cnt <= '0;
      else                bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= EMPTY;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    set_ovr    = 1'b0;
    unique case (state)
      EMPTY: begin
        if (word_done) begin
          load       = 1'b1;
          state_next = FULL;
        end
      end
      FULL: begin
        if (out_ready) begin
          if (word_done) load = 1'b1;
          else           state_next = EMPTY;
        end else if (word_done) begin
          set_ovr = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    data_out <= '0;
    else if (load) data_out <= shreg_next;
  end

  // A new drop takes priority over a clear on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           overrun <= 1'b0;
    else if (set_ovr)     overrun <= 1'b1;
    else if (overrun_clr) overrun <= 1'b0;
  end

  assign out_valid = (state == FULL);

endmodule
